// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared constants, state type and request-legality helper for the load/store data-memory controller.
package lsu_pkg;

  localparam int LANE_BYTES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Stores allow only B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response channel between the execute stage (master) and the LSU (slave).
interface lsu_dmem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_dmem_ctrl_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane(s) and extend per funct3.
  always_comb begin
    byte_s = word[{off, 3'b000} +: 8];
    half_s = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'h000000, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'h0000, half_s};
      F3_W:    load_data = word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Replace the target lane(s) of the read word with right-justified store data.
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller between the RV32I execute stage and d_mem; sub-word stores are read-modify-write.
// Build option MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing natural alignment.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_dmem_ctrl_if.slave        bus,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_add,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  lsu_state_t            state_r, state_s;
  logic                  we_r, we_s;
  logic [2:0]            f3_r, f3_s;
  logic [1:0]            off_r, off_s;
  logic [ADDR_WIDTH-1:0] add_r, add_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic                  ren_r, ren_s;
  logic                  wen_r, wen_s;
  logic [DATA_WIDTH-1:0] mwdata_r, mwdata_s;
  logic                  rvalid_r, rvalid_s;
  logic                  rerr_r, rerr_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic [1:0]            req_off_s;
  logic                  err_s;
  logic [DATA_WIDTH-1:0] load_data_s, store_word_s;

  lsu_lane_align u_align (
    .word       (mem_rdata),
    .off        (off_r),
    .funct3     (f3_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .store_word (store_word_s)
  );

  // Request decode: effective lane offset and the error condition.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   req_off_s = bus.req_addr[1:0];
      2'b01:   req_off_s = {bus.req_addr[1], 1'b0};
      default: req_off_s = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    case (bus.req_funct3[1:0])
      2'b00:   err_s = !f3_legal(bus.req_we, bus.req_funct3);
      2'b01:   err_s = !f3_legal(bus.req_we, bus.req_funct3) || bus.req_addr[0];
      default: err_s = !f3_legal(bus.req_we, bus.req_funct3) || (|bus.req_addr[1:0]);
    endcase
`else
    err_s = !f3_legal(bus.req_we, bus.req_funct3);
`endif
  end

  // Next-state and next-output logic; every output is a flop loaded from here.
  always_comb begin
    state_s  = state_r;
    we_s     = we_r;
    f3_s     = f3_r;
    off_s    = off_r;
    add_s    = add_r;
    wdata_s  = wdata_r;
    mwdata_s = mwdata_r;
    ren_s    = 1'b0;
    wen_s    = 1'b0;
    rvalid_s = 1'b0;
    rerr_s   = 1'b0;
    rdata_s  = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          we_s    = bus.req_we;
          f3_s    = bus.req_funct3;
          off_s   = req_off_s;
          add_s   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_s = bus.req_wdata;
          if (err_s) begin
            state_s  = RESP;
            rvalid_s = 1'b1;
            rerr_s   = 1'b1;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_s  = WR;
            wen_s    = 1'b1;
            mwdata_s = bus.req_wdata;
          end else begin
            state_s = RD;
            ren_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (we_r) begin
          state_s  = WR;
          wen_s    = 1'b1;
          mwdata_s = store_word_s;
        end else begin
          state_s  = RESP;
          rvalid_s = 1'b1;
          rdata_s  = load_data_s;
        end
      end
      WR: begin
        state_s  = RESP;
        rvalid_s = 1'b1;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      we_r     <= 1'b0;
      f3_r     <= 3'b000;
      off_r    <= 2'b00;
      add_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
      mwdata_r <= {DATA_WIDTH{1'b0}};
      ren_r    <= 1'b0;
      wen_r    <= 1'b0;
      rvalid_r <= 1'b0;
      rerr_r   <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      we_r     <= we_s;
      f3_r     <= f3_s;
      off_r    <= off_s;
      add_r    <= add_s;
      wdata_r  <= wdata_s;
      mwdata_r <= mwdata_s;
      ren_r    <= ren_s;
      wen_r    <= wen_s;
      rvalid_r <= rvalid_s;
      rerr_r   <= rerr_s;
      rdata_r  <= rdata_s;
    end
  end

  // The write strobe is masked by reset so an abandoned store never lands in memory.
  assign mem_wen        = wen_r & ~rst;
  assign mem_ren        = ren_r;
  assign mem_add        = add_r;
  assign mem_wdata      = mwdata_r;
  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = rvalid_r;
  assign bus.resp_rdata = rdata_r;
  assign bus.resp_err   = rerr_r;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: byte-level reference memory, directed test-plan cases, then random traffic.
module tb_lsu_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [11:0] mem_add;
  logic [31:0] mem_rdata, mem_wdata;
  logic [31:0] dmem [1024];
  logic [7:0]  rmem [4096];
  int          cyc;
  int          total;
  int          bad;
  bit          quiet;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ren;
    int          wen;
    logic [11:0] add;
    logic [31:0] wword;
    int          acc;
    bit          has_c;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];

  lsu_dmem_ctrl_if bus ();

  lsu_dmem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_add   (mem_add),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'h8899_AABB;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Stand-in for d_mem: combinational read, write on the clock edge.
  assign mem_rdata = dmem[mem_add[11:2]];
  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_wen) dmem[mem_add[11:2]] = mem_wdata;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: RV32I load/store semantics on a byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int size, a;
    bit legal, sgn;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    a = int'(addr);
`ifdef MISALIGN_TRAP_EN
    if ((a % size) != 0) legal = 1'b0;
`else
    a = a - (a % size);
`endif
    e.rdata = 32'h0; e.err = 1'b0; e.ren = 0; e.wen = 0; e.wword = 32'h0;
    e.add = 12'(a & 32'hFFC); e.has_c = 1'b0; e.c = 32'h0; e.acc = 0;
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(rmem[a+i]) << (8*i));
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      e.rdata = v;
      e.lat = 2;
      e.ren = 1;
    end else begin
      for (int i = 0; i < size; i++) rmem[a+i] = 8'(wd >> (8*i));
      for (int i = 0; i < 4; i++) e.wword = e.wword | (32'(rmem[int'(e.add)+i]) << (8*i));
      e.ren = (size < 4) ? 1 : 0;
      e.wen = 1;
      e.lat = (size < 4) ? 3 : 2;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wd, input bit push, input bit has_c, input logic [31:0] c);
    exp_t e;
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got=0 want=1 (cycle %0d)", cyc);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    if (push) begin
      model(we, f3, addr, wd, e);
      e.acc = cyc + 1;
      e.has_c = has_c;
      e.c = c;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = 12'($urandom_range(0, 4095));
    bus.req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got=%0d want=0 pending", sb.size());
    end
  endtask

  task automatic monitor();
    int ren_n, wen_n;
    exp_t e;
    ren_n = 0;
    wen_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ren_n = 0;
        wen_n = 0;
      end else if (!quiet) begin
        if (mem_ren) begin
          ren_n++;
          if (sb.size() > 0) chk("ren_addr", 32'(mem_add), 32'(sb[0].add));
          else chk("stray_ren", 32'(mem_ren), 32'h0);
        end
        if (mem_wen) begin
          wen_n++;
          if (sb.size() > 0) begin
            chk("wen_addr", 32'(mem_add), 32'(sb[0].add));
            chk("wdata", mem_wdata, sb[0].wword);
          end else begin
            chk("stray_wen", 32'(mem_wen), 32'h0);
          end
        end
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(bus.resp_valid), 32'h0);
          end else begin
            e = sb.pop_front();
            chk("rdata", bus.resp_rdata, e.rdata);
            chk("err", 32'(bus.resp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("ren_cycles", 32'(ren_n), 32'(e.ren));
            chk("wen_cycles", 32'(wen_n), 32'(e.wen));
            if (e.has_c) chk("plan_value", bus.resp_rdata, e.c);
          end
          ren_n = 0;
          wen_n = 0;
        end
      end
    end
  endtask

  task automatic stimulus();
    int n;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_mem_ren", 32'(mem_ren), 32'h0);
    chk("rst_mem_wen", 32'(mem_wen), 32'h0);
    chk("rst_mem_add", 32'(mem_add), 32'h0);
    chk("rst_outs", bus.resp_rdata | mem_wdata | 32'(bus.resp_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);

    issue(1'b0, 3'd2, 12'h100, 32'h0, 1'b1, 1'b1, 32'h8899_AABB);
    issue(1'b0, 3'd0, 12'h103, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF88);
    issue(1'b0, 3'd4, 12'h103, 32'h0, 1'b1, 1'b1, 32'h0000_0088);
    issue(1'b0, 3'd1, 12'h102, 32'h0, 1'b1, 1'b1, 32'hFFFF_8899);
    issue(1'b0, 3'd5, 12'h100, 32'h0, 1'b1, 1'b1, 32'h0000_AABB);
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'd2, 12'h101, 32'h0, 1'b1, 1'b1, 32'h0000_0000);
`else
    issue(1'b0, 3'd2, 12'h101, 32'h0, 1'b1, 1'b1, 32'h8899_AABB);
`endif
    issue(1'b0, 3'd3, 12'h100, 32'h0, 1'b1, 1'b1, 32'h0000_0000);
    issue(1'b1, 3'd0, 12'h101, 32'h1234_5677, 1'b1, 1'b0, 32'h0);
    issue(1'b1, 3'd1, 12'h102, 32'h0000_CAFE, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 3'd2, 12'h100, 32'h0, 1'b1, 1'b1, 32'hCAFE_77BB);
    issue(1'b1, 3'd2, 12'hFFC, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 3'd2, 12'hFFC, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    drain();

    // Reset during the write cycle of a byte store must drop the store and its response.
    quiet = 1'b1;
    issue(1'b1, 3'd0, 12'h100, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
    n = 0;
    while (!mem_wen && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr", 32'(mem_wen), 32'h1);
    rst = 1'b1;
    #1;
    chk("wen_gated", 32'(mem_wen), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);
      @(negedge clk);
    end
    quiet = 1'b0;
    issue(1'b0, 3'd2, 12'h100, 32'h0, 1'b1, 1'b1, 32'hCAFE_77BB);

    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      if ($urandom_range(0, 1) == 1) a = 12'h100 + 12'($urandom_range(0, 31));
      else a = 12'($urandom_range(0, 4095));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1, 1'b0, 32'h0);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    total = 0;
    bad = 0;
    quiet = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 12'h000;
    bus.req_wdata  = 32'h0;
    for (int w = 0; w < 1024; w++)
      for (int b = 0; b < 4; b++) rmem[4*w+b] = 8'(init_word(w) >> (8*b));
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
